mux_pipeline_arbiter: RTL

Round-robin, credit-gated scheduler that sits directly upstream of the pipelined multiplexer, choosing which of INPUT_COUNT requesters drives the multiplexer each cycle. It drives the multiplexer select and grants the winning requester. It also carries a tag delay line matched to the multiplexer latency, so the consumer receives `out_valid`/`out_sel` aligned with the multiplexer output word. Downstream back-pressure is handled with credits, because the multiplexer pipeline itself cannot stall.

---
 rtl/mux_pipeline_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mux_pipeline_arbiter.sv
// ---------------------------------------------------------------------------
// mux_pipeline_arbiter
//
// Round-robin, credit-gated scheduler placed directly upstream of a pipelined
// multiplexer. Each cycle it picks one of INPUT_COUNT requesters and drives the
// multiplexer select. A tag delay line matched to the multiplexer latency
// produces out_valid/out_sel aligned with the multiplexer output word. The
// multiplexer pipeline cannot stall, so downstream back-pressure is handled
// with credits.
//
// Parameters:
//   INPUT_COUNT  number of requesters (>= 2)
//   LATENCY      multiplexer latency in edges from sel to out (>= 1)
//   CREDITS      downstream buffer depth (>= 1)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req            level request per channel
//   req_last       (MUX_PIPELINE_ARBITER_HOLD_EN only) last word of a burst
//   credit_return  one-cycle pulse, consumer freed one slot
//   sel/sel_valid  registered multiplexer select and its qualifier
//   grant          one-hot grant, same cycle as sel_valid
//   out_valid      multiplexer output holds a granted word
//   out_sel        channel that produced the current multiplexer output
//   credits        credits currently available
//   credit_err     sticky: a return arrived while credits == CREDITS
//
// Optional feature: define MUX_PIPELINE_ARBITER_HOLD_EN to enable burst lock
// (stay on a channel until its req_last word issues or its req drops).
// ---------------------------------------------------------------------------
module mux_pipeline_arbiter #(
  parameter int INPUT_COUNT = 2,
  parameter int LATENCY     = 1,
  parameter int CREDITS     = 4,
  localparam int SEL_W      = $clog2(INPUT_COUNT),
  localparam int CNT_W      = $clog2(CREDITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_COUNT-1:0] req,
`ifdef MUX_PIPELINE_ARBITER_HOLD_EN
  input  logic [INPUT_COUNT-1:0] req_last,
`endif
  input  logic                   credit_return,
  output logic [SEL_W-1:0]       sel,
  output logic                   sel_valid,
  output logic [INPUT_COUNT-1:0] grant,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       out_sel,
  output logic [CNT_W-1:0]       credits,
  output logic                   credit_err
);

  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   sel_valid_q, sel_valid_d;
  logic [INPUT_COUNT-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       credits_q, credits_d;
  logic                   credit_err_q, credit_err_d;
  logic [LATENCY-1:0]            dl_valid_q, dl_valid_d;
  logic [LATENCY-1:0][SEL_W-1:0] dl_sel_q, dl_sel_d;

  logic             issue;
  logic             ret_ok;
  logic [SEL_W-1:0] rr_winner;
  logic [SEL_W-1:0] winner;
  logic             found;
  int               idx;

`ifdef MUX_PIPELINE_ARBITER_HOLD_EN
  logic lock_q, lock_d;
`endif

  // Round-robin search: first requester scanning upward from last+1, wrapping.
  always_comb begin
    rr_winner = last_q;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= INPUT_COUNT; i++) begin
      idx = (int'(last_q) + i) % INPUT_COUNT;
      if (!found && req[idx]) begin
        rr_winner = SEL_W'(idx);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    issue  = (|req) && (credits_q != '0);
    winner = rr_winner;
`ifdef MUX_PIPELINE_ARBITER_HOLD_EN
    // While locked the held channel is always last_q, since a lock is only
    // taken on an issue that also updates last_q.
    if (lock_q && req[last_q]) winner = last_q;
`endif
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_d        = sel_q;
    sel_valid_d  = 1'b0;
    grant_d      = '0;
    last_d       = last_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;

    if (issue) begin
      sel_d       = winner;
      sel_valid_d = 1'b1;
      grant_d     = INPUT_COUNT'(1) << winner;
      last_d      = winner;
    end

    // A return while the counter is full is dropped and flagged sticky.
    ret_ok = credit_return && (credits_q != CNT_W'(CREDITS));
    if (credit_return && !ret_ok) credit_err_d = 1'b1;

    case ({issue, ret_ok})
      2'b10:   credits_d = credits_q - CNT_W'(1);
      2'b01:   credits_d = credits_q + CNT_W'(1);
      default: credits_d = credits_q;
    endcase

    // Tag delay line shifts every cycle regardless of issue.
    dl_valid_d[0] = sel_valid_q;
    dl_sel_d[0]   = sel_q;
    for (int i = 1; i < LATENCY; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_sel_d[i]   = dl_sel_q[i-1];
    end
  end

`ifdef MUX_PIPELINE_ARBITER_HOLD_EN
  always_comb begin
    lock_d = lock_q;
    if (issue)              lock_d = !req_last[winner];
    else if (!req[last_q])  lock_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      grant_q      <= '0;
      last_q       <= SEL_W'(INPUT_COUNT - 1);
      credits_q    <= CNT_W'(CREDITS);
      credit_err_q <= 1'b0;
      // NOTE: the delay line is reset (unlike a plain data array) because
      // in-flight tags must not surface as out_valid after a reset.
      dl_valid_q   <= '0;
      dl_sel_q     <= '0;
`ifdef MUX_PIPELINE_ARBITER_HOLD_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      dl_valid_q   <= dl_valid_d;
      dl_sel_q     <= dl_sel_d;
`ifdef MUX_PIPELINE_ARBITER_HOLD_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign grant      = grant_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;
  assign out_valid  = dl_valid_q[LATENCY-1];
  assign out_sel    = dl_sel_q[LATENCY-1];

endmodule
